// File: rtl/io_arbiter_if.sv
// Two-port request/grant bus shared by the CPU (port 0) and a secondary master (port 1).
// The master modport is the requester side; the slave modport is the arbiter side.
interface io_arbiter_if;
   logic        req0, req1;
   logic        we0, we1;
   logic [15:0] addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1;
   logic        ack0, ack1;
   logic [15:0] rdata;
   logic        err;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, ack0, ack1, rdata, err
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, ack0, ack1, rdata, err
   );
endinterface

// File: rtl/io_arbiter.sv
// Round-robin arbiter/sequencer for the I/O page (LED and button registers) at 0xFFE0-0xFFFF.
// Optional feature macro IO_ARB_EDGE_CAPTURE_EN: button reads return sticky rising-edge flags.
module io_arbiter (
   input  logic               clk,
   input  logic               reset,
   io_arbiter_if.slave        bus,
   input  logic [15:0]        botones,
   output logic [15:0]        leds,
   output logic               ce
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [11:0] PAGE_LED = 12'hFFF;
   localparam logic [11:0] PAGE_BTN = 12'hFFE;

   state_t      state_q, state_d;
   logic        prio_q, prio_d;
   logic        win_q, win_d;
   logic        we_q, we_d;
   logic [11:0] page_q, page_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] leds_q, leds_d;
   logic [15:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [15:0] sync1_q, sync1_d;
   logic [15:0] sync2_q, sync2_d;
   logic        win;

`ifdef IO_ARB_EDGE_CAPTURE_EN
   logic [15:0] sync2_dly_q, sync2_dly_d;
   logic [15:0] flags_q, flags_d;
   logic        flags_clr;
`endif

   // Only addr[15:4] selects a register; the low nibble is a don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.addr0[3:0], bus.addr1[3:0]};

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      state_d  = state_q;
      prio_d   = prio_q;
      win_d    = win_q;
      we_d     = we_q;
      page_d   = page_q;
      wdata_d  = wdata_q;
      leds_d   = leds_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      sync1_d  = botones;
      sync2_d  = sync1_q;
      win      = 1'b0;
`ifdef IO_ARB_EDGE_CAPTURE_EN
      sync2_dly_d = sync2_q;
      flags_clr   = 1'b0;
`endif

      case (state_q)
         IDLE: begin
            if (bus.req0 || bus.req1) begin
               // Contention goes to the priority port; a lone requester always wins.
               win     = (bus.req0 && bus.req1) ? prio_q : bus.req1;
               win_d   = win;
               prio_d  = ~win;
               we_d    = win ? bus.we1 : bus.we0;
               page_d  = win ? bus.addr1[15:4] : bus.addr0[15:4];
               wdata_d = win ? bus.wdata1 : bus.wdata0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            rdata_d = '0;
            err_d   = 1'b0;
            case (page_q)
               PAGE_LED: begin
                  if (we_q) leds_d = wdata_q;
                  else      rdata_d = leds_q;
               end
               PAGE_BTN: begin
                  if (!we_q) begin
`ifdef IO_ARB_EDGE_CAPTURE_EN
                     rdata_d   = flags_q;
                     flags_clr = 1'b1;
`else
                     rdata_d   = sync2_q;
`endif
                  end
               end
               default: err_d = 1'b1;
            endcase
            state_d = DONE;
         end
         DONE: begin
            rdata_d = '0;
            err_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef IO_ARB_EDGE_CAPTURE_EN
      // A new edge on the clearing cycle survives: set is OR'ed in after the clear.
      flags_d = (flags_q & ~{16{flags_clr}}) | (sync2_q & ~sync2_dly_q);
`endif
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it simply wins over any update on the same edge,
      // including a write that was about to commit in ACCESS.
      if (!reset) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         win_q   <= 1'b0;
         we_q    <= 1'b0;
         page_q  <= '0;
         wdata_q <= '0;
         leds_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         sync1_q <= '0;
         sync2_q <= '0;
`ifdef IO_ARB_EDGE_CAPTURE_EN
         sync2_dly_q <= '0;
         flags_q     <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q <= state_d;
         prio_q  <= prio_d;
         win_q   <= win_d;
         we_q    <= we_d;
         page_q  <= page_d;
         wdata_q <= wdata_d;
         leds_q  <= leds_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
`ifdef IO_ARB_EDGE_CAPTURE_EN
         sync2_dly_q <= sync2_dly_d;
         flags_q     <= flags_d;
`endif
      end
   end

   assign bus.gnt0  = (state_q == ACCESS) && !win_q;
   assign bus.gnt1  = (state_q == ACCESS) &&  win_q;
   assign bus.ack0  = (state_q == DONE)   && !win_q;
   assign bus.ack1  = (state_q == DONE)   &&  win_q;
   assign bus.rdata = rdata_q;
   assign bus.err   = err_q;
   assign leds      = leds_q;

   // Data memory is selected for any CPU address outside 0xFFE0-0xFFFF.
   assign ce = (bus.addr0[15:5] != 11'h7FF);

endmodule

// File: tb/tb_io_arbiter.sv
// Directed self-checking bench for io_arbiter; button checks follow IO_ARB_EDGE_CAPTURE_EN.
module tb_io_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] botones;
   logic [15:0] leds;
   logic        ce;
   int          tests_run = 0;
   int          tests_failed = 0;

   io_arbiter_if bus ();

   io_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .botones (botones),
      .leds    (leds),
      .ce      (ce)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      botones = '0;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      step(2);
      check("rst_gnt0",  {15'd0, bus.gnt0}, 16'd0);
      check("rst_gnt1",  {15'd0, bus.gnt1}, 16'd0);
      check("rst_ack0",  {15'd0, bus.ack0}, 16'd0);
      check("rst_ack1",  {15'd0, bus.ack1}, 16'd0);
      check("rst_err",   {15'd0, bus.err},  16'd0);
      check("rst_rdata", bus.rdata, 16'h0000);
      check("rst_leds",  leds, 16'h0000);
      reset = 1'b1;

      // Single LED write by port 0, then read-back.
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'hFFF3; bus.wdata0 = 16'hA5A5;
      step(1);
      check("wr_gnt0",  {15'd0, bus.gnt0}, 16'd1);
      check("wr_ack0_early", {15'd0, bus.ack0}, 16'd0);
      step(1);
      check("wr_ack0",  {15'd0, bus.ack0}, 16'd1);
      check("wr_gnt0_off", {15'd0, bus.gnt0}, 16'd0);
      check("wr_leds",  leds, 16'hA5A5);
      check("wr_err",   {15'd0, bus.err}, 16'd0);
      bus.req0 = 1'b0;
      step(1);
      check("wr_ack0_off", {15'd0, bus.ack0}, 16'd0);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'hFFF0;
      step(2);
      check("rd_ack0",  {15'd0, bus.ack0}, 16'd1);
      check("rd_rdata", bus.rdata, 16'hA5A5);
      bus.req0 = 1'b0;
      step(1);

      // Contention after reset: grants alternate 0,1,0 every 3 cycles.
      reset = 1'b0;
      step(1);
      check("rst2_leds", leds, 16'h0000);
      reset = 1'b1;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'hFFF0;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'hFFF8; bus.wdata1 = 16'h1111;
      step(1);
      check("rr1_gnt", {14'd0, bus.gnt1, bus.gnt0}, 16'b01);
      step(1);
      check("rr1_ack", {14'd0, bus.ack1, bus.ack0}, 16'b01);
      check("rr1_rdata", bus.rdata, 16'h0000);
      step(1);
      check("rr_idle", {12'd0, bus.gnt1, bus.gnt0, bus.ack1, bus.ack0}, 16'd0);
      step(1);
      check("rr2_gnt", {14'd0, bus.gnt1, bus.gnt0}, 16'b10);
      step(1);
      check("rr2_ack", {14'd0, bus.ack1, bus.ack0}, 16'b10);
      check("rr2_leds", leds, 16'h1111);
      step(2);
      check("rr3_gnt", {14'd0, bus.gnt1, bus.gnt0}, 16'b01);
      step(1);
      check("rr3_ack", {14'd0, bus.ack1, bus.ack0}, 16'b01);
      check("rr3_rdata", bus.rdata, 16'h1111);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step(1);

      // Out-of-range read by port 1, and ce decode boundaries.
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h1234;
      step(2);
      check("oor_ack1",  {15'd0, bus.ack1}, 16'd1);
      check("oor_err",   {15'd0, bus.err},  16'd1);
      check("oor_rdata", bus.rdata, 16'h0000);
      check("oor_leds",  leds, 16'h1111);
      bus.req1 = 1'b0;
      step(1);
      check("oor_err_off", {15'd0, bus.err}, 16'd0);
      bus.addr0 = 16'h1234; #1;
      check("ce_1234", {15'd0, ce}, 16'd1);
      bus.addr0 = 16'hFFE7; #1;
      check("ce_ffe7", {15'd0, ce}, 16'd0);
      bus.addr0 = 16'hFFDF; #1;
      check("ce_ffdf", {15'd0, ce}, 16'd1);
      bus.addr0 = 16'hFFFF; #1;
      check("ce_ffff", {15'd0, ce}, 16'd0);

      // Button write is acknowledged without side effects.
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'hFFE0; bus.wdata1 = 16'hDEAD;
      step(2);
      check("bw_ack1", {15'd0, bus.ack1}, 16'd1);
      check("bw_err",  {15'd0, bus.err},  16'd0);
      check("bw_leds", leds, 16'h1111);
      bus.req1 = 1'b0;
      step(1);

`ifdef IO_ARB_EDGE_CAPTURE_EN
      botones = 16'h0004;
      step(3);
      botones = 16'h0000;
      step(3);
      // Edge on bit 0 lands on the clearing edge of the first read.
      botones = 16'h0001;
      step(1);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'hFFE0;
      step(2);
      check("cap_rd1", bus.rdata, 16'h0004);
      bus.req0 = 1'b0;
      step(1);
      bus.req0 = 1'b1;
      step(2);
      check("cap_rd2", bus.rdata, 16'h0001);
      bus.req0 = 1'b0;
      step(1);
      bus.req0 = 1'b1;
      step(2);
      check("cap_rd3", bus.rdata, 16'h0000);
      bus.req0 = 1'b0;
      step(1);
`else
      botones = 16'h8001;
      step(3);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'hFFE0;
      step(2);
      check("lvl_ack0", {15'd0, bus.ack0}, 16'd1);
      check("lvl_rd",   bus.rdata, 16'h8001);
      bus.req0 = 1'b0;
      step(1);
`endif

      // Reset during ACCESS aborts the write and restores priority to port 0.
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'hFFF0; bus.wdata0 = 16'hFFFF;
      step(1);
      check("mid_gnt0", {15'd0, bus.gnt0}, 16'd1);
      reset = 1'b0; bus.req0 = 1'b0;
      step(1);
      check("mid_ack0", {15'd0, bus.ack0}, 16'd0);
      check("mid_gnt0_off", {15'd0, bus.gnt0}, 16'd0);
      check("mid_leds", leds, 16'h0000);
      reset = 1'b1;
      step(1);
      check("mid_ack0_after", {15'd0, bus.ack0}, 16'd0);
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'hFFF0;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'hFFF0;
      step(1);
      check("mid_prio_gnt", {14'd0, bus.gnt1, bus.gnt0}, 16'b01);
      step(1);
      check("mid_prio_ack", {14'd0, bus.ack1, bus.ack0}, 16'b01);
      check("mid_rdata", bus.rdata, 16'h0000);
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      step(1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/io_arbiter.md
# io_arbiter

Arbiter and sequencer for the memory-mapped I/O page (0xFFE0–0xFFFF) of the single-cycle CPU. It shares the LED output register and the button input register between two requesters: port 0 (CPU) and port 1 (secondary master, e.g. a debug or DMA unit). It serialises accesses through a three-state handshake FSM, synchronises and captures button presses, and drives the data-memory chip enable for CPU addresses outside the I/O page.

## Interface
- No parameters. Data and address width fixed at 16.
- Clock and reset: one clock; reset is synchronous and active-low.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- req0, req1  in  1  access request from port 0 / port 1; held high until the matching ack
- we0, we1  in  1  1 = write, 0 = read; sampled with req
- addr0, addr1  in  16  access address
- wdata0, wdata1  in  16  write data
- gnt0, gnt1  out  1  high while that port's access is in progress
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid while ack0 or ack1 is high
- err  out  1  pulses with ack when the address is outside the I/O page
- botones  in  16  raw asynchronous buttons
- leds  out  16  LED register
- ce  out  1  combinational: 1 when addr0 is outside 0xFFE0–0xFFFF (data memory selected), else 0

## Operation
- Decode: addr[15:4]=0xFFF selects the LED register; addr[15:4]=0xFFE selects the button register; any other address is out of range. addr[3:0] is ignored.
- FSM states:
  - IDLE: if any req, choose a winner and latch its we/addr/wdata, then go to ACCESS.
  - ACCESS: gnt for the winner is high. Perform the access at the closing edge, then go to DONE.
  - DONE: ack for the winner and rdata are valid, then go to IDLE.
- Arbitration: round-robin. A priority bit points to the preferred port and flips to the other port after each grant. Reset value points to port 0.
  - Single requester always wins.
- LED write: leds <= wdata. LED read: rdata = leds.
- Button write: acknowledged, no effect. Button read: see Configuration.
- Out-of-range access: no state change, rdata=0, err=1 with ack.
- Buttons pass through a 2-flop synchronizer (sync2) before any use.
- A request dropped before its ack is a protocol violation. Behaviour is undefined and not checked.

## Timing
- Reset values: gnt0=gnt1=0, ack0=ack1=0, err=0, rdata=0, leds=0, FSM=IDLE, priority=port 0, synchronizer and capture flags=0.
- req high at edge E → ACCESS and gnt during E..E+1 → DONE, ack/rdata/err during E+1..E+2 → IDLE at E+2.
- Latency from request to ack is 2 cycles. Throughput is one access per 3 cycles.
- A requester still holding req after its ack is treated as a new request in IDLE.
- leds takes its new value at the ACCESS→DONE edge, so it is visible in the ack cycle.
- Button latency: a press is visible in the sync2 level 2 edges after botones changes.
- Reset mid-operation: reset low at any edge forces reset values. An in-flight write is not committed and no ack is issued.
- ce is purely combinational from addr0 and independent of the FSM.

## Configuration
- IO_ARB_EDGE_CAPTURE_EN defined:
  - Button reads return 16 sticky flags; bit i sets on a rising edge of synchronized button i.
  - A button read clears all flags at the ACCESS→DONE edge; rdata carries the pre-clear value.
  - If a new edge occurs on the clearing edge, that bit stays set (set beats clear).
- IO_ARB_EDGE_CAPTURE_EN undefined: button reads return the synchronized level sync2 directly. No flags and no read-clear side effect.

## Test plan
- Reset then single write: port 0 writes 0xA5A5 to 0xFFF3 → gnt0 one cycle, ack0 two cycles after req, leds=0xA5A5 in the ack cycle, err=0. A following read of 0xFFF0 returns rdata=0xA5A5.
- Simultaneous req0/req1 held continuously after reset → grants alternate port 0, port 1, port 0, with ack spacing of 3 cycles.
- Out-of-range: port 1 reads 0x1234 → ack1 with err=1, rdata=0, leds unchanged. ce=1 for addr0=0x1234 and ce=0 for addr0=0xFFE7.
- Edge capture (macro on): pulse botones[2] for 3 cycles, then read 0xFFE0 → rdata=0x0004; second read → 0x0000. With a new edge on bit 0 at the clear edge → second read returns 0x0001. Macro off: hold botones=0x8001 → read returns 0x8001.
- Reset mid-access: port 0 writes 0xFFFF to 0xFFF0, reset low during the ACCESS cycle → no ack0, leds=0, FSM in IDLE, priority back to port 0.
